// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, access size
// codes and the wait-counter sizing derived from the largest allowed latency.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } stateT;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/data_mem_responder_byte_lane_unit.sv
// Combinational byte-lane helper: extracts and extends a load byte, and merges
// a store byte into the addressed little-endian lane of a word.
module byte_lane_unit (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic        signExt,
  input  logic [7:0]  storeByte,
  output logic [31:0] loadValue,
  output logic [31:0] mergedWord
);

  logic [7:0] laneByte;

  always_comb begin
    laneByte   = 8'h00;
    mergedWord = word;
    case (lane)
      2'd0: begin laneByte = word[7:0];   mergedWord[7:0]   = storeByte; end
      2'd1: begin laneByte = word[15:8];  mergedWord[15:8]  = storeByte; end
      2'd2: begin laneByte = word[23:16]; mergedWord[23:16] = storeByte; end
      default: begin laneByte = word[31:24]; mergedWord[31:24] = storeByte; end
    endcase
    loadValue = {{24{signExt & laneByte[7]}}, laneByte};
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for the pipeline's memory stage: accepts
// one load/store, waits LATENCY cycles, then issues a one-cycle response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        RspError,
  output logic        Stall
);

  localparam int              IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0]     IDX_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  stateT            state, nextState;
  logic [CNT_W-1:0] cnt;

  logic        latWrite, latSigned;
  logic [1:0]  latSize;
  logic [31:0] latAddr, latWData;

  logic        curWrite, curSigned;
  logic [1:0]  curSize;
  logic [31:0] curAddr, curWData;

  logic        accept, enterResp;
  logic        sizeBad, misaligned, outOfRange, reqError;
  logic [IDX_W-1:0] memIdx;
  logic [31:0] memWord, byteLoad, mergedWord, storeWord, rspNext;
  logic        memWrite;

  logic [31:0] mem [DEPTH_WORDS];

  assign ReqReady = (state == ST_IDLE);
  assign accept   = (state == ST_IDLE) && ReqValid;
  assign Stall    = accept || (state == ST_WAIT);

  // With zero latency the array is accessed on the acceptance edge itself, so
  // the live request must be used before it has reached the latches.
  assign curWrite  = (state == ST_IDLE) ? ReqWrite  : latWrite;
  assign curSize   = (state == ST_IDLE) ? ReqSize   : latSize;
  assign curSigned = (state == ST_IDLE) ? ReqSigned : latSigned;
  assign curAddr   = (state == ST_IDLE) ? ReqAddr   : latAddr;
  assign curWData  = (state == ST_IDLE) ? ReqWData  : latWData;

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (ReqValid) nextState = (LATENCY > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == '0) nextState = ST_RESP;
      ST_RESP: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  assign enterResp  = (nextState == ST_RESP);
  assign sizeBad    = (curSize != SIZE_BYTE) && (curSize != SIZE_WORD);
  assign misaligned = (curSize == SIZE_WORD) && (curAddr[1:0] != 2'b00);
  assign outOfRange = (curAddr[31:2] >= IDX_LIMIT);
  assign reqError   = sizeBad || misaligned || outOfRange;

  assign memIdx  = curAddr[IDX_W+1:2];
  assign memWord = mem[memIdx];

  byte_lane_unit uLane (
    .word       (memWord),
    .lane       (curAddr[1:0]),
    .signExt    (curSigned),
    .storeByte  (curWData[7:0]),
    .loadValue  (byteLoad),
    .mergedWord (mergedWord)
  );

  assign storeWord = (curSize == SIZE_WORD) ? curWData : mergedWord;
  assign memWrite  = enterResp && curWrite && !reqError && !Rst;
  assign rspNext   = (reqError || curWrite) ? 32'h0
                   : ((curSize == SIZE_WORD) ? memWord : byteLoad);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      latWrite  <= 1'b0;
      latSize   <= 2'b00;
      latSigned <= 1'b0;
      latAddr   <= 32'h0;
      latWData  <= 32'h0;
      RspValid  <= 1'b0;
      RspError  <= 1'b0;
      RspData   <= 32'h0;
    end else begin
      state <= nextState;
      if (accept) begin
        latWrite  <= ReqWrite;
        latSize   <= ReqSize;
        latSigned <= ReqSigned;
        latAddr   <= ReqAddr;
        latWData  <= ReqWData;
        cnt       <= CNT_LOAD;
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      RspValid <= enterResp;
      RspError <= enterResp && reqError;
      RspData  <= enterResp ? rspNext : 32'h0;
    end
  end

  // Contents survive reset on purpose; only the request path is cleared.
  always_ff @(posedge Clk) begin
    if (memWrite) mem[memIdx] <= storeWord;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=2 for the
// load/store/error/reset scenarios, one at LATENCY=0 for back-to-back streaming.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        reqValid, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWData;
  logic        reqReady, rspValid, rspError, stall;
  logic [31:0] rspData;

  logic        reqValid0, reqWrite0, reqSigned0;
  logic [1:0]  reqSize0;
  logic [31:0] reqAddr0, reqWData0;
  logic        reqReady0, rspValid0, rspError0, stall0;
  logic [31:0] rspData0;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .Clk(clk), .Rst(rst), .ReqValid(reqValid), .ReqReady(reqReady),
    .ReqWrite(reqWrite), .ReqSize(reqSize), .ReqSigned(reqSigned),
    .ReqAddr(reqAddr), .ReqWData(reqWData), .RspValid(rspValid),
    .RspData(rspData), .RspError(rspError), .Stall(stall)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .Clk(clk), .Rst(rst), .ReqValid(reqValid0), .ReqReady(reqReady0),
    .ReqWrite(reqWrite0), .ReqSize(reqSize0), .ReqSigned(reqSigned0),
    .ReqAddr(reqAddr0), .ReqWData(reqWData0), .RspValid(rspValid0),
    .RspData(rspData0), .RspError(rspError0), .Stall(stall0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request in an IDLE cycle, then follows it to its response and
  // leaves the bench one cycle later, back in IDLE.
  task automatic applyStimulus(input string tag, input logic write, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input logic expErr);
    int edges;
    edges = 0;
    checkOutput({tag, " ready"}, {31'd0, reqReady}, 32'd1);
    reqValid  = 1'b1;
    reqWrite  = write;
    reqSize   = size;
    reqSigned = sgn;
    reqAddr   = addr;
    reqWData  = wdata;
    #1;
    checkOutput({tag, " stallIdle"}, {31'd0, stall}, 32'd1);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        reqValid  = 1'b0;
        reqWrite  = ~write;
        reqSize   = 2'b01;
        reqSigned = ~sgn;
        reqAddr   = 32'hFFFF_FFFC;
        reqWData  = 32'h0F0F_0F0F;
      end
      if (rspValid) begin
        edges = i;
        break;
      end
    end
    checkOutput({tag, " latency"}, edges, LAT + 1);
    if (edges != 0) begin
      checkOutput({tag, " data"}, rspData, expData);
      checkOutput({tag, " err"}, {31'd0, rspError}, {31'd0, expErr});
      checkOutput({tag, " stallResp"}, {31'd0, stall}, 32'd0);
      checkOutput({tag, " readyResp"}, {31'd0, reqReady}, 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, " validAfter"}, {31'd0, rspValid}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic sawRsp;
    rst = 1'b1;
    reqValid = 0; reqWrite = 0; reqSize = 2'b10; reqSigned = 0; reqAddr = 0; reqWData = 0;
    reqValid0 = 0; reqWrite0 = 0; reqSize0 = 2'b10; reqSigned0 = 0; reqAddr0 = 0; reqWData0 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset ready", {31'd0, reqReady}, 32'd1);
    checkOutput("reset valid", {31'd0, rspValid}, 32'd0);
    checkOutput("reset err", {31'd0, rspError}, 32'd0);
    checkOutput("reset data", rspData, 32'h0);
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    checkOutput("reset ready0", {31'd0, reqReady0}, 32'd1);

    // Zero-latency instance with the request held high: alternate IDLE/RESP.
    reqValid0 = 1'b1; reqWrite0 = 1'b1; reqSize0 = 2'b10;
    reqAddr0 = 32'h4; reqWData0 = 32'h0BAD_F00D;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end else #1;
      checkOutput($sformatf("lat0 stall%0d", k), {31'd0, stall0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("lat0 valid%0d", k), {31'd0, rspValid0}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    reqValid0 = 1'b0;
    @(posedge clk); #1;
    reqValid0 = 1'b1; reqWrite0 = 1'b0;
    @(posedge clk); #1;
    reqValid0 = 1'b0;
    checkOutput("lat0 load valid", {31'd0, rspValid0}, 32'd1);
    checkOutput("lat0 load data", rspData0, 32'h0BAD_F00D);
    checkOutput("lat0 load err", {31'd0, rspError0}, 32'd0);
    @(posedge clk); #1;

    applyStimulus("sw 0x10", 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
    applyStimulus("lw 0x10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
    applyStimulus("lb 0x13", 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFF_FFDE, 0);
    applyStimulus("lbu 0x13", 0, 2'b00, 0, 32'h13, 32'h0, 32'h0000_00DE, 0);
    applyStimulus("lb 0x10", 0, 2'b00, 1, 32'h10, 32'h0, 32'hFFFF_FFEF, 0);
    applyStimulus("sb 0x11", 1, 2'b00, 0, 32'h11, 32'hFFFF_FF5A, 32'h0, 0);
    applyStimulus("lw merged", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_5AEF, 0);
    applyStimulus("lbu 0x12", 0, 2'b00, 0, 32'h12, 32'h0, 32'h0000_00AD, 0);
    applyStimulus("lw misalign", 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1);
    applyStimulus("sw 0x0", 1, 2'b10, 0, 32'h0, 32'hCAFE_F00D, 32'h0, 0);
    applyStimulus("sw range", 1, 2'b10, 0, 32'h1000, 32'h1111_1111, 32'h0, 1);
    applyStimulus("lw 0x0 kept", 0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0);
    applyStimulus("lw size01", 0, 2'b01, 0, 32'h10, 32'h0, 32'h0, 1);
    applyStimulus("sw size11", 1, 2'b11, 0, 32'h10, 32'h2222_2222, 32'h0, 1);
    applyStimulus("lw 0x10 kept", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_5AEF, 0);
    applyStimulus("sw 0x20", 1, 2'b10, 0, 32'h20, 32'hA5A5_A5A5, 32'h0, 0);

    // Reset in the middle of a store's wait must drop it entirely.
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqSigned = 0;
    reqAddr = 32'h20; reqWData = 32'h1234_5678;
    @(posedge clk); #1;
    reqValid = 1'b0;
    checkOutput("abort stallWait", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort readyInReset", {31'd0, reqReady}, 32'd1);
    checkOutput("abort stallInReset", {31'd0, stall}, 32'd0);
    sawRsp = rspValid;
    repeat (3) begin @(posedge clk); #1; sawRsp = sawRsp | rspValid; end
    rst = 1'b0;
    #1;
    checkOutput("abort readyAfter", {31'd0, reqReady}, 32'd1);
    repeat (4) begin @(posedge clk); #1; sawRsp = sawRsp | rspValid; end
    checkOutput("abort noRsp", {31'd0, sawRsp}, 32'd0);
    applyStimulus("lw 0x20 prior", 0, 2'b10, 0, 32'h20, 32'h0, 32'hA5A5_A5A5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the backing store.
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 0..15, meaning the number of wait cycles between request acceptance and the response cycle.
REQ-003 Port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port ReqValid, input, 1 bit: the pipeline's memory stage is presenting a load or store.
REQ-006 Port ReqReady, output, 1 bit: the responder can accept a request this cycle.
REQ-007 Port ReqWrite, input, 1 bit: 1 = store, 0 = load.
REQ-008 Port ReqSize, input, 2 bits: 00 = byte, 10 = word; 01 and 11 are illegal.
REQ-009 Port ReqSigned, input, 1 bit: for byte loads, 1 = sign-extend (lb), 0 = zero-extend.
REQ-010 Port ReqAddr, input, 32 bits: byte address.
REQ-011 Port ReqWData, input, 32 bits: store data; for byte stores only bits [7:0] are used.
REQ-012 Port RspValid, output, 1 bit: one-cycle response strobe.
REQ-013 Port RspData, output, 32 bits: load result, valid only while RspValid=1.
REQ-014 Port RspError, output, 1 bit: error flag, valid only while RspValid=1.
REQ-015 Port Stall, output, 1 bit: hold request for the IF/ID, ID/EX and EX/MEM pipeline stages.

Function
REQ-016 The block SHALL implement the FSM states IDLE, WAIT and RESP.
- ReqReady=1 only in IDLE.
REQ-017 In IDLE with ReqValid=1, the block SHALL latch ReqWrite, ReqSize, ReqSigned, ReqAddr and ReqWData.
- Next state is WAIT if LATENCY>0, otherwise RESP.
REQ-018 WAIT SHALL load a down-counter with LATENCY-1 on entry and go to RESP when the counter is 0.
- Inputs are ignored during WAIT.
REQ-019 RESP SHALL last exactly one cycle with RspValid=1, then return to IDLE.
- ReqReady=0 in RESP, so the minimum request spacing is LATENCY+2 cycles.
REQ-020 Acceptance at edge T SHALL give RspValid=1 in the cycle following edge T+LATENCY+1.
REQ-021 Stall SHALL be (IDLE and ReqValid) or WAIT, combinationally.
- Stall is 0 in RESP, so the pipeline advances on the response cycle.
REQ-022 Word index = latched address [31:2]; byte lane = address [1:0], little-endian (lane n = bits 8n+7..8n).
REQ-023 Error conditions, each giving RspError=1 and RspData=0 with no memory modification:
- word access with address [1:0] not 00;
- word index >= DEPTH_WORDS;
- illegal ReqSize.
REQ-024 A store SHALL commit on the edge that enters RESP.
- A word store writes all 32 bits; a byte store writes only the addressed lane.
- A store response has RspData=0.
REQ-025 A load SHALL read the array on the edge entering RESP and register the result into RspData.
- Word load: the full word.
- Byte load: the lane, extended per the latched ReqSigned.
REQ-026 Outside RESP, RspValid, RspError and RspData SHALL be 0.
REQ-027 The backing store SHALL be one word-addressed array, with read and write both occurring at the RESP-entry edge.
- Back-to-back read-after-write therefore returns the newly written data.

Reset
REQ-028 Rst=1 SHALL immediately force the FSM to IDLE, the counter to 0, the request latches to 0, RspValid=0, RspError=0 and RspData=0.
REQ-029 Reset during WAIT SHALL abandon the request: no store commits and no response is issued.
REQ-030 Array contents SHALL NOT be cleared by reset.
REQ-031 After reset deassertion, ReqReady SHALL be 1 in the first cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the ReqSize codes (SIZE_BYTE=00, SIZE_WORD=10) and the LATENCY maximum constant.
REQ-033 Byte-lane extract/extend and lane-merge logic SHALL be a combinational sub-module named byte_lane_unit.

Verification
REQ-034 With LATENCY=2: word store 0xDEADBEEF to 0x10 accepted at edge 0, then word load from 0x10 -> RspValid in the cycle after edge 3 both times, load RspData=0xDEADBEEF, RspError=0.
REQ-035 After REQ-034: lb from 0x13 -> 0xFFFFFFDE; lbu (ReqSigned=0) from 0x13 -> 0x000000DE; lb from 0x10 -> 0xFFFFFFEF.
REQ-036 Byte store 0x5A to 0x11 over word 0xDEADBEEF -> subsequent word load from 0x10 returns 0xDEAD5AEF.
REQ-037 Error cases: word load from 0x12 -> RspError=1, RspData=0; word store to 0x1000 (index 1024) -> RspError=1 and array unchanged; ReqSize=01 -> RspError=1.
REQ-038 Reset asserted during the WAIT of a store 0x12345678 to 0x20 -> no RspValid, ReqReady=1 after release, and a word load from 0x20 returns the prior contents.
REQ-039 LATENCY=0 with ReqValid held high continuously -> RspValid every second cycle and Stall pattern 1,0,1,0.
